// File: rtl/pzcorebus_csr_arbiter.sv
// Round-robin N:1 CSR command arbiter with in-order response routing back to requesters.
// Optional build macro PZCOREBUS_CSR_ARBITER_ID_CHECK_EN adds the sticky o_sid_mismatch checker.
module pzcorebus_csr_arbiter #(
    parameter int REQUESTERS  = 4,
    parameter int ID_WIDTH    = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int OUTSTANDING = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [REQUESTERS-1:0]            i_mcmd_valid,
    output logic [REQUESTERS-1:0]            o_scmd_accept,
    input  logic [2*REQUESTERS-1:0]          i_mcmd,
    input  logic [ID_WIDTH*REQUESTERS-1:0]   i_mid,
    input  logic [ADDR_WIDTH*REQUESTERS-1:0] i_maddr,
    input  logic [DATA_WIDTH*REQUESTERS-1:0] i_mdata,
    output logic [REQUESTERS-1:0]            o_sresp_valid,
    input  logic [REQUESTERS-1:0]            i_mresp_accept,
    output logic [ID_WIDTH-1:0]              o_sid,
    output logic                             o_serror,
    output logic [DATA_WIDTH-1:0]            o_sdata,
    output logic                             o_mcmd_valid,
    input  logic                             i_scmd_accept,
    output logic [1:0]                       o_mcmd,
    output logic [ID_WIDTH-1:0]              o_mid,
    output logic [ADDR_WIDTH-1:0]            o_maddr,
    output logic [DATA_WIDTH-1:0]            o_mdata,
    input  logic                             i_sresp_valid,
    output logic                             o_mresp_accept,
    input  logic [ID_WIDTH-1:0]              i_sid,
    input  logic                             i_serror,
    input  logic [DATA_WIDTH-1:0]            i_sdata
`ifdef PZCOREBUS_CSR_ARBITER_ID_CHECK_EN
    ,
    output logic                             o_sid_mismatch
`endif
);

    localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [1:0] CMD_POSTED = 2'b01;

    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                lock_q, lock_d;
    logic [IDX_W-1:0]    lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]    fifo_idx_q [OUTSTANDING];
    logic [IDX_W-1:0]    fifo_idx_d [OUTSTANDING];
    logic [ID_WIDTH-1:0] fifo_mid_q [OUTSTANDING];
    logic [ID_WIDTH-1:0] fifo_mid_d [OUTSTANDING];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [REQUESTERS-1:0] eligible;
    logic                  arb_found;
    logic [IDX_W-1:0]      arb_idx;
    logic [IDX_W:0]        cand_sum;
    logic [IDX_W-1:0]      cand;
    logic [IDX_W-1:0]      grant;
    logic [1:0]            grant_cmd;
    logic                  cmd_valid;
    logic                  cmd_fire;
    logic                  push;
    logic                  pop;
    logic [IDX_W-1:0]      head_idx;
    logic                  unused_sid;

    assign fifo_full  = (count_q == CNT_W'(OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign head_idx   = fifo_idx_q[rd_ptr_q];
    assign unused_sid = ^i_sid;

    // Posted writes never occupy a tracking slot, so they stay eligible when the FIFO is full.
    always_comb begin
        eligible = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            eligible[k] = i_mcmd_valid[k] && ((i_mcmd[2*k +: 2] == CMD_POSTED) || !fifo_full);
        end
    end

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand_sum >= (IDX_W+1)'(REQUESTERS)) begin
                cand_sum = cand_sum - (IDX_W+1)'(REQUESTERS);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!arb_found && eligible[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign grant     = lock_q ? lock_idx_q : arb_idx;
    assign cmd_valid = !i_rst && (lock_q ? i_mcmd_valid[lock_idx_q] : arb_found);
    assign cmd_fire  = cmd_valid && i_scmd_accept;
    assign grant_cmd = i_mcmd[2*grant +: 2];
    assign push      = cmd_fire && (grant_cmd != CMD_POSTED);
    assign pop       = !i_rst && i_sresp_valid && !fifo_empty && i_mresp_accept[head_idx];

    assign o_mcmd_valid = cmd_valid;
    assign o_mcmd       = grant_cmd;
    assign o_mid        = ID_WIDTH'(grant);
    assign o_maddr      = i_maddr[ADDR_WIDTH*grant +: ADDR_WIDTH];
    assign o_mdata      = i_mdata[DATA_WIDTH*grant +: DATA_WIDTH];

    always_comb begin
        o_scmd_accept = '0;
        if (cmd_valid) begin
            o_scmd_accept[grant] = i_scmd_accept;
        end
    end

    // With nothing tracked, a downstream response is stray and is swallowed.
    always_comb begin
        o_sresp_valid = '0;
        if (!i_rst && !fifo_empty) begin
            o_sresp_valid[head_idx] = i_sresp_valid;
        end
    end

    assign o_mresp_accept = (i_rst || fifo_empty) ? 1'b1 : i_mresp_accept[head_idx];
    assign o_sid          = fifo_mid_q[rd_ptr_q];
    assign o_serror       = i_serror;
    assign o_sdata        = i_sdata;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (cmd_fire) begin
            rr_ptr_d = (grant == IDX_W'(REQUESTERS - 1)) ? '0 : grant + 1'b1;
            lock_d   = 1'b0;
        end else if (cmd_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
    end

    always_comb begin
        fifo_idx_d = fifo_idx_q;
        fifo_mid_d = fifo_mid_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_idx_d[wr_ptr_q] = grant;
            fifo_mid_d[wr_ptr_q] = i_mid[ID_WIDTH*grant +: ID_WIDTH];
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        fifo_idx_q <= fifo_idx_d;
        fifo_mid_q <= fifo_mid_d;
    end

`ifdef PZCOREBUS_CSR_ARBITER_ID_CHECK_EN
    logic sid_mismatch_q, sid_mismatch_d;

    always_comb begin
        sid_mismatch_d = sid_mismatch_q;
        if (pop && (i_sid[IDX_W-1:0] != head_idx)) begin
            sid_mismatch_d = 1'b1;
        end
        if (!i_rst && i_sresp_valid && fifo_empty) begin
            sid_mismatch_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sid_mismatch_q <= 1'b0;
        end else begin
            sid_mismatch_q <= sid_mismatch_d;
        end
    end

    assign o_sid_mismatch = sid_mismatch_q;
`endif

endmodule

// File: tb/tb_pzcorebus_csr_arbiter.sv
// Self-checking bench for pzcorebus_csr_arbiter: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_pzcorebus_csr_arbiter;
    localparam int R  = 4;
    localparam int IW = 8;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int OS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            i_rst;
    logic [R-1:0]    i_mcmd_valid;
    logic [R-1:0]    o_scmd_accept;
    logic [2*R-1:0]  i_mcmd;
    logic [IW*R-1:0] i_mid;
    logic [AW*R-1:0] i_maddr;
    logic [DW*R-1:0] i_mdata;
    logic [R-1:0]    o_sresp_valid;
    logic [R-1:0]    i_mresp_accept;
    logic [IW-1:0]   o_sid;
    logic            o_serror;
    logic [DW-1:0]   o_sdata;
    logic            o_mcmd_valid;
    logic            i_scmd_accept;
    logic [1:0]      o_mcmd;
    logic [IW-1:0]   o_mid;
    logic [AW-1:0]   o_maddr;
    logic [DW-1:0]   o_mdata;
    logic            i_sresp_valid;
    logic            o_mresp_accept;
    logic [IW-1:0]   i_sid;
    logic            i_serror;
    logic [DW-1:0]   i_sdata;
`ifdef PZCOREBUS_CSR_ARBITER_ID_CHECK_EN
    logic            o_sid_mismatch;
`endif

    pzcorebus_csr_arbiter #(
        .REQUESTERS(R), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTANDING(OS)
    ) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_mcmd_valid(i_mcmd_valid), .o_scmd_accept(o_scmd_accept), .i_mcmd(i_mcmd),
        .i_mid(i_mid), .i_maddr(i_maddr), .i_mdata(i_mdata),
        .o_sresp_valid(o_sresp_valid), .i_mresp_accept(i_mresp_accept),
        .o_sid(o_sid), .o_serror(o_serror), .o_sdata(o_sdata),
        .o_mcmd_valid(o_mcmd_valid), .i_scmd_accept(i_scmd_accept), .o_mcmd(o_mcmd),
        .o_mid(o_mid), .o_maddr(o_maddr), .o_mdata(o_mdata),
        .i_sresp_valid(i_sresp_valid), .o_mresp_accept(o_mresp_accept),
        .i_sid(i_sid), .i_serror(i_serror), .i_sdata(i_sdata)
`ifdef PZCOREBUS_CSR_ARBITER_ID_CHECK_EN
        , .o_sid_mismatch(o_sid_mismatch)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic          c_valid [R];
    logic [1:0]    c_cmd   [R];
    logic [IW-1:0] c_mid   [R];
    logic [AW-1:0] c_addr  [R];
    logic [DW-1:0] c_data  [R];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < R; k++) begin
            i_mcmd_valid[k]      = c_valid[k];
            i_mcmd[2*k +: 2]     = c_cmd[k];
            i_mid[IW*k +: IW]    = c_mid[k];
            i_maddr[AW*k +: AW]  = c_addr[k];
            i_mdata[DW*k +: DW]  = c_data[k];
        end
    endtask

    task automatic idle();
        for (int k = 0; k < R; k++) begin
            c_valid[k] = 1'b0;
            c_cmd[k]   = 2'b00;
            c_mid[k]   = IW'(8'h10 + k);
            c_addr[k]  = AW'(16'h1000 * (k + 1));
            c_data[k]  = DW'(32'hD000_0000 + k);
        end
        i_scmd_accept  = 1'b0;
        i_sresp_valid  = 1'b0;
        i_mresp_accept = '0;
        i_sid          = '0;
        i_serror       = 1'b0;
        i_sdata        = '0;
        drive();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
    endtask

    // Single requester issues one command that is accepted this cycle.
    task automatic issue(input int k, input logic [1:0] cmd, input logic [IW-1:0] mid, input string nm);
        idle();
        c_valid[k] = 1'b1;
        c_cmd[k]   = cmd;
        c_mid[k]   = mid;
        i_scmd_accept = 1'b1;
        drive();
        @(negedge clk);
        chk(nm, o_scmd_accept, 64'(4'b0001 << k));
        cycle();
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [1:0] cmd;
        logic       acc;
        logic       exp_mv;
        logic [7:0] exp_mid;
        logic [3:0] exp_sacc;
    } vec_t;
    vec_t vt [12];

    typedef struct {
        int            idx;
        logic [IW-1:0] mid;
    } trk_t;
    trk_t mq [$];

    initial begin
        int  rr_m;
        bit  lock_m;
        int  lock_idx_m;
        bit  pend [R];
        bit  ev;
        int  g;
        int  h;
        int  cnd;
        logic [3:0] exp_sacc;
        logic [3:0] exp_sr;
        logic       exp_ma;
        logic       rv;
        logic       sacc;

        vt[0]  = '{1'b1, 4'hF, 2'b00, 1'b1, 1'b0, 8'h00, 4'h0};
        vt[1]  = '{1'b0, 4'hF, 2'b00, 1'b1, 1'b1, 8'h00, 4'h1};
        vt[2]  = '{1'b0, 4'hE, 2'b00, 1'b1, 1'b1, 8'h01, 4'h2};
        vt[3]  = '{1'b0, 4'hC, 2'b00, 1'b1, 1'b1, 8'h02, 4'h4};
        vt[4]  = '{1'b0, 4'h8, 2'b00, 1'b1, 1'b1, 8'h03, 4'h8};
        vt[5]  = '{1'b1, 4'h0, 2'b00, 1'b1, 1'b0, 8'h00, 4'h0};
        vt[6]  = '{1'b0, 4'h4, 2'b00, 1'b0, 1'b1, 8'h02, 4'h0};
        vt[7]  = '{1'b0, 4'h5, 2'b00, 1'b0, 1'b1, 8'h02, 4'h0};
        vt[8]  = '{1'b0, 4'h5, 2'b00, 1'b0, 1'b1, 8'h02, 4'h0};
        vt[9]  = '{1'b0, 4'h5, 2'b00, 1'b1, 1'b1, 8'h02, 4'h4};
        vt[10] = '{1'b0, 4'h9, 2'b00, 1'b1, 1'b1, 8'h03, 4'h8};
        vt[11] = '{1'b0, 4'h1, 2'b00, 1'b1, 1'b1, 8'h00, 4'h1};

        i_rst = 1'b1;
        idle();

        // Vector table: reset, four-way round robin, lock under backpressure.
        for (int i = 0; i < 12; i++) begin
            idle();
            i_rst = vt[i].rst;
            for (int k = 0; k < R; k++) begin
                c_valid[k] = vt[i].valid[k];
                c_cmd[k]   = vt[i].cmd;
            end
            i_scmd_accept = vt[i].acc;
            i_sresp_valid = vt[i].rst;
            drive();
            @(negedge clk);
            chk($sformatf("vec%0d_mvalid", i), o_mcmd_valid, vt[i].exp_mv);
            chk($sformatf("vec%0d_sacc", i), o_scmd_accept, vt[i].exp_sacc);
            if (vt[i].exp_mv) chk($sformatf("vec%0d_mid", i), o_mid, vt[i].exp_mid);
            if (vt[i].rst) begin
                chk($sformatf("vec%0d_rst_sresp", i), o_sresp_valid, 0);
                chk($sformatf("vec%0d_rst_macc", i), o_mresp_accept, 1);
            end
            cycle();
        end
        i_rst = 1'b0;

        // Outstanding limit blocks reads but not posted writes.
        do_reset();
        for (int n = 0; n < 4; n++) issue(1, 2'b00, IW'(n), "lim_read");
        idle();
        c_valid[1] = 1'b1;
        c_valid[3] = 1'b1;
        c_cmd[3]   = 2'b01;
        i_scmd_accept = 1'b1;
        drive();
        @(negedge clk);
        chk("lim_posted_acc", o_scmd_accept, 4'b1000);
        chk("lim_posted_cmd", o_mcmd, 2'b01);
        cycle();
        c_valid[3] = 1'b0;
        drive();
        @(negedge clk);
        chk("lim_blocked_mv", o_mcmd_valid, 0);
        chk("lim_blocked_acc", o_scmd_accept, 0);
        cycle();

        // In-order response routing with restored IDs and response backpressure.
        do_reset();
        issue(0, 2'b00, 8'h11, "rsp_cmd0");
        issue(2, 2'b10, 8'h22, "rsp_cmd2");
        idle();
        i_sresp_valid  = 1'b1;
        i_sdata        = 32'hA5A5A5A5;
        i_serror       = 1'b1;
        i_mresp_accept = 4'hF;
        @(negedge clk);
        chk("rsp0_valid", o_sresp_valid, 4'b0001);
        chk("rsp0_sid", o_sid, 8'h11);
        chk("rsp0_data", o_sdata, 32'hA5A5A5A5);
        chk("rsp0_err", o_serror, 1);
        chk("rsp0_macc", o_mresp_accept, 1);
        cycle();
        i_sdata        = 32'h5A5A5A5A;
        i_serror       = 1'b0;
        i_mresp_accept = 4'b1011;
        @(negedge clk);
        chk("rsp1_valid", o_sresp_valid, 4'b0100);
        chk("rsp1_sid", o_sid, 8'h22);
        chk("rsp1_stall", o_mresp_accept, 0);
        cycle();
        i_mresp_accept = 4'hF;
        @(negedge clk);
        chk("rsp1b_valid", o_sresp_valid, 4'b0100);
        chk("rsp1b_macc", o_mresp_accept, 1);
        cycle();
        i_mresp_accept = 4'h0;
        @(negedge clk);
        chk("stray_valid", o_sresp_valid, 0);
        chk("stray_macc", o_mresp_accept, 1);
        cycle();
`ifdef PZCOREBUS_CSR_ARBITER_ID_CHECK_EN
        @(negedge clk);
        chk("stray_mismatch", o_sid_mismatch, 1);
`endif

        // Full/boundary: push+pop same cycle, no pop credit when full, mismatch flag.
        do_reset();
        issue(0, 2'b00, 8'h01, "full_r0a");
        issue(0, 2'b00, 8'h02, "full_r0b");
        issue(0, 2'b00, 8'h03, "full_r0c");
        idle();
        c_valid[1] = 1'b1;
        c_mid[1]   = 8'h33;
        i_scmd_accept  = 1'b1;
        i_sresp_valid  = 1'b1;
        i_mresp_accept = 4'hF;
        drive();
        @(negedge clk);
        chk("pp_acc", o_scmd_accept, 4'b0010);
        chk("pp_resp", o_sresp_valid, 4'b0001);
        cycle();
        issue(2, 2'b11, 8'h44, "full_r2");
        idle();
        c_valid[3] = 1'b1;
        c_mid[3]   = 8'h55;
        i_scmd_accept = 1'b1;
        drive();
        @(negedge clk);
        chk("full_blocked", o_scmd_accept, 0);
        cycle();
        i_sresp_valid  = 1'b1;
        i_mresp_accept = 4'hF;
        @(negedge clk);
        chk("full_nocredit", o_scmd_accept, 0);
        chk("full_pop_resp", o_sresp_valid, 4'b0001);
        cycle();
        i_sresp_valid = 1'b0;
        @(negedge clk);
        chk("full_after_pop", o_scmd_accept, 4'b1000);
        cycle();
        idle();
        i_sresp_valid  = 1'b1;
        i_mresp_accept = 4'hF;
        i_sid          = 8'h03;
        for (int n = 0; n < 4; n++) begin
            logic [7:0] esid [4];
            esid[0] = 8'h03; esid[1] = 8'h33; esid[2] = 8'h44; esid[3] = 8'h55;
            @(negedge clk);
            chk($sformatf("drain%0d_valid", n), o_sresp_valid, 64'(4'b0001 << (n % 4)));
            chk($sformatf("drain%0d_sid", n), o_sid, esid[n]);
            cycle();
            i_sid = IW'(n + 1);
        end
        i_sresp_valid = 1'b0;
`ifdef PZCOREBUS_CSR_ARBITER_ID_CHECK_EN
        @(negedge clk);
        chk("mm_sticky", o_sid_mismatch, 1);
        do_reset();
        @(negedge clk);
        chk("mm_cleared", o_sid_mismatch, 0);
`endif

        // Randomized traffic against a queue-based reference model.
        do_reset();
        rr_m = 0; lock_m = 0; lock_idx_m = 0;
        mq.delete();
        for (int k = 0; k < R; k++) pend[k] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < R; k++) begin
                if (!pend[k] && ($urandom_range(1, 0) == 1)) begin
                    pend[k]   = 1;
                    c_cmd[k]  = 2'($urandom);
                    c_mid[k]  = IW'($urandom);
                    c_addr[k] = AW'($urandom);
                    c_data[k] = DW'($urandom);
                end
                c_valid[k] = pend[k];
            end
            sacc = ($urandom_range(3, 0) != 0);
            rv   = (mq.size() > 0) && ($urandom_range(1, 0) == 1);
            i_scmd_accept  = sacc;
            i_sresp_valid  = rv;
            i_sid          = (mq.size() > 0) ? IW'(mq[0].idx) : '0;
            i_sdata        = DW'($urandom);
            i_serror       = 1'($urandom);
            i_mresp_accept = 4'($urandom);
            drive();

            ev = 0; g = 0;
            if (lock_m) begin
                ev = 1; g = lock_idx_m;
            end else begin
                for (int i = 0; i < R; i++) begin
                    cnd = (rr_m + i) % R;
                    if (!ev && pend[cnd] && (c_cmd[cnd] == 2'b01 || mq.size() < OS)) begin
                        ev = 1; g = cnd;
                    end
                end
            end
            exp_sacc = (ev && sacc) ? 4'(1 << g) : 4'h0;
            h = (mq.size() > 0) ? mq[0].idx : 0;
            exp_sr = (rv && mq.size() > 0) ? 4'(1 << h) : 4'h0;
            exp_ma = (mq.size() > 0) ? i_mresp_accept[h] : 1'b1;

            @(negedge clk);
            chk("rnd_mvalid", o_mcmd_valid, ev);
            chk("rnd_sacc", o_scmd_accept, exp_sacc);
            if (ev) begin
                chk("rnd_mid", o_mid, g);
                chk("rnd_cmd", o_mcmd, c_cmd[g]);
                chk("rnd_addr", o_maddr, c_addr[g]);
                chk("rnd_data", o_mdata, c_data[g]);
            end
            chk("rnd_sresp", o_sresp_valid, exp_sr);
            chk("rnd_macc", o_mresp_accept, exp_ma);
            if (rv) begin
                chk("rnd_sid", o_sid, mq[0].mid);
                chk("rnd_sdata", o_sdata, i_sdata);
            end

            @(posedge clk);
            if (rv && mq.size() > 0 && i_mresp_accept[h]) void'(mq.pop_front());
            if (ev && sacc) begin
                if (c_cmd[g] != 2'b01) mq.push_back('{g, c_mid[g]});
                rr_m    = (g + 1) % R;
                lock_m  = 0;
                pend[g] = 0;
            end else if (ev) begin
                lock_m     = 1;
                lock_idx_m = g;
            end
            #1;
        end
`ifdef PZCOREBUS_CSR_ARBITER_ID_CHECK_EN
        @(negedge clk);
        chk("rnd_no_mismatch", o_sid_mismatch, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
